id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: none; datapath fixed at 32 bits, register numbers 5 bits.
REQ-002 clk  in  1  rising-edge clock, single clock domain.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_valid  in  1  ID-stage instruction valid.
REQ-005 stall  in  1  hold all stage registers.
REQ-006 flush  in  1  replace captured instruction with bubble.
REQ-007 id_rs_data, id_rt_data  in  32 each  register-file read data.
REQ-008 id_imm16  in  16  instruction immediate field.
REQ-009 id_rs, id_rt, id_rd  in  5 each  register numbers.
REQ-010 id_funct  in  6; id_ALUOp  in  2; id_ALUSrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg  in  1 each.
REQ-011 exmem_RegWrite  in  1; exmem_rd  in  5; exmem_result  in  32  EX/MEM writeback source.
REQ-012 memwb_RegWrite  in  1; memwb_rd  in  5; memwb_data  in  32  MEM/WB writeback source.
REQ-013 data1, data2  out  32  ALU operands (rs side, rt/immediate side).
REQ-014 ALU_control  out  4  ALU operation code.
REQ-015 ex_valid  out  1; ex_write_reg  out  5; ex_rt_data  out  32  store data; ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg  out  1 each.
REQ-016 load_use_stall  out  1  load-use hazard request to ID/IF.

Function
REQ-017 Stage registers update on rising clk; priority rst > flush > stall > load.
REQ-018 Load: capture rs/rt data, rs/rt numbers, sign-extended imm (bit 15 replicated into [31:16]), ex_write_reg = RegDst ? rd : rt, control bits, ex_valid = id_valid; latency ID to EX outputs one cycle.
REQ-019 id_valid=0 on load: control bits (RegWrite, MemRead, MemWrite, MemtoReg) captured as 0, ex_valid=0.
REQ-020 Flush: ex_valid and all control bits 0, rs/rt numbers 0; data registers don't-care but SHALL be 0.
REQ-021 Stall (no flush): every stage register holds; flush with stall asserted SHALL still flush.
REQ-022 ALU_control registered from decode: ALUOp 00->2 (add); 01->6 (sub); 11->15; 10 by funct: 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x2A->7, 0x27->12, any other->15.
REQ-023 Forwarded rs (combinational): EX/MEM match (exmem_RegWrite, exmem_rd!=0, exmem_rd==ex_rs) -> exmem_result; else MEM/WB match -> memwb_data; else registered rs data; EX/MEM wins when both match.
REQ-024 Forwarded rt: identical rules against ex_rt.
REQ-025 data1 = forwarded rs; data2 = ex ALUSrc ? sign-extended imm : forwarded rt; ex_rt_data = forwarded rt always.
REQ-026 Register 0 never forwarded; registered zero value passes through.
REQ-027 load_use_stall = ex_valid & ex_MemRead & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt), combinational, independent of stall.

Reset
REQ-028 rst at clock edge: all stage registers 0; ALU_control=0, ex_valid=0, ex_write_reg=0, all control outputs 0, load_use_stall=0.
REQ-029 rst mid-operation discards captured instruction; no partial state survives; first load follows first edge with rst low.

Configuration
REQ-030 Macro ID_EX_FORWARD_EN defined: REQ-023/024 forwarding present.
REQ-031 Macro undefined: forwarded rs/rt equal registered values, exmem_*/memwb_* ignored, load_use_stall still generated.

Verification
REQ-032 rst=1 one edge -> all outputs 0, ex_valid=0.
REQ-033 Load ALUOp=10 funct=0x2A, rs=3 data 5, rt=4 data 9, ALUSrc=0 -> next cycle ALU_control=7, data1=5, data2=9.
REQ-034 Load imm16=0xFFFC, ALUSrc=1, ALUOp=00 -> data2=0xFFFFFFFC, ALU_control=2.
REQ-035 ex_rs=3; exmem_rd=3 result 0x11, memwb_rd=3 data 0x22, both RegWrite -> data1=0x11; exmem_rd=0 -> data1=0x22 (macro defined).
REQ-036 ex MemRead=1, ex_rt=8, id_rs=8 -> load_use_stall=1; next edge flush=1, stall=1 -> ex_valid=0, controls 0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
//
// Signal bundle between the ID stage, the writeback/forwarding sources and the
// ID/EX pipeline register (id_ex_stage). clk and rst are not part of the bundle.
//
// Modports
//   master : the surrounding pipeline. Drives the decoded instruction, the
//            stall/flush controls and the EX/MEM and MEM/WB writeback sources;
//            observes the EX-side outputs and the load-use request.
//   slave  : id_ex_stage itself. The direction of every signal is the reverse
//            of master.
//
// Signal summary
//   id_valid, stall, flush                      stage controls
//   id_rs_data, id_rt_data [31:0]               register-file read data
//   id_imm16 [15:0]                             raw immediate field
//   id_rs, id_rt, id_rd [4:0]                   register numbers
//   id_funct [5:0], id_ALUOp [1:0]              ALU decode inputs
//   id_ALUSrc, id_RegDst, id_RegWrite,
//   id_MemRead, id_MemWrite, id_MemtoReg        decoded control bits
//   exmem_RegWrite, exmem_rd, exmem_result      EX/MEM writeback source
//   memwb_RegWrite, memwb_rd, memwb_data        MEM/WB writeback source
//   data1, data2 [31:0]                         ALU operands
//   ALU_control [3:0]                           ALU operation code
//   ex_valid, ex_write_reg [4:0], ex_rt_data    EX-stage instruction state
//   ex_RegWrite, ex_MemRead, ex_MemWrite,
//   ex_MemtoReg                                 EX-stage control bits
//   load_use_stall                              load-use hazard request
// ---------------------------------------------------------------------------
interface id_ex_stage_if;
    // ID-stage side
    logic        id_valid;
    logic        stall;
    logic        flush;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_ALUOp;
    logic        id_ALUSrc;
    logic        id_RegDst;
    logic        id_RegWrite;
    logic        id_MemRead;
    logic        id_MemWrite;
    logic        id_MemtoReg;

    // Writeback sources used for forwarding
    logic        exmem_RegWrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_RegWrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;

    // EX-stage side
    logic [31:0] data1;
    logic [31:0] data2;
    logic [3:0]  ALU_control;
    logic        ex_valid;
    logic [4:0]  ex_write_reg;
    logic [31:0] ex_rt_data;
    logic        ex_RegWrite;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_MemtoReg;
    logic        load_use_stall;

    modport master (
        output id_valid, stall, flush,
        output id_rs_data, id_rt_data, id_imm16,
        output id_rs, id_rt, id_rd, id_funct, id_ALUOp,
        output id_ALUSrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
        output exmem_RegWrite, exmem_rd, exmem_result,
        output memwb_RegWrite, memwb_rd, memwb_data,
        input  data1, data2, ALU_control,
        input  ex_valid, ex_write_reg, ex_rt_data,
        input  ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
        input  load_use_stall
    );

    modport slave (
        input  id_valid, stall, flush,
        input  id_rs_data, id_rt_data, id_imm16,
        input  id_rs, id_rt, id_rd, id_funct, id_ALUOp,
        input  id_ALUSrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
        input  exmem_RegWrite, exmem_rd, exmem_result,
        input  memwb_RegWrite, memwb_rd, memwb_data,
        output data1, data2, ALU_control,
        output ex_valid, ex_write_reg, ex_rt_data,
        output ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
        output load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for a 32-bit, 32-register MIPS-style pipeline.
// Captures the decoded instruction, decodes the ALU operation one stage early,
// selects the ALU operands (with optional EX/MEM and MEM/WB forwarding) and
// raises a load-use hazard request towards ID/IF.
//
// Ports
//   clk : rising-edge clock, single domain
//   rst : synchronous, active-high reset
//   bus : id_ex_stage_if.slave (decoded instruction in, operands/controls out)
//
// Register update priority: rst > flush > stall > load.
//   rst / flush : the stage becomes a bubble (every register cleared)
//   stall       : every register holds
//   load        : the ID instruction is captured; an invalid ID slot keeps
//                 its data but carries no side-effecting control bits
//
// Configuration
//   ID_EX_FORWARD_EN defined   : operand forwarding from EX/MEM (priority)
//                                and MEM/WB is present.
//   ID_EX_FORWARD_EN undefined : operands come straight from the stage
//                                registers; exmem_* / memwb_* are ignored.
//   The load-use request is generated in both builds.
// ---------------------------------------------------------------------------
module id_ex_stage (
    input  logic           clk,
    input  logic           rst,
    id_ex_stage_if.slave   bus
);

    // ALU operation codes driven on ALU_control
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_INV = 4'd15;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALUOp encoding from the main decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OTHER = 2'b11
    } aluop_e;

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  write_reg_q;
    logic [3:0]  alu_control_q;
    logic        valid_q;
    logic        alusrc_q;
    logic        regwrite_q;
    logic        memread_q;
    logic        memwrite_q;
    logic        memtoreg_q;

    // Forwarded operand values
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // -----------------------------------------------------------------------
    // ALU control decode (done in ID so EX sees a registered code)
    // -----------------------------------------------------------------------
    function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                              input logic [5:0] funct);
        logic [3:0] code;
        code = ALU_INV;
        case (aluop_e'(alu_op))
            ALUOP_ADD:   code = ALU_ADD;
            ALUOP_SUB:   code = ALU_SUB;
            ALUOP_OTHER: code = ALU_INV;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: code = ALU_ADD;
                    FUNCT_SUB: code = ALU_SUB;
                    FUNCT_AND: code = ALU_AND;
                    FUNCT_OR:  code = ALU_OR;
                    FUNCT_SLT: code = ALU_SLT;
                    FUNCT_NOR: code = ALU_NOR;
                    default:   code = ALU_INV;
                endcase
            end
            default:     code = ALU_INV;
        endcase
        return code;
    endfunction

    logic [31:0] id_imm_sext;
    logic [4:0]  id_write_reg;
    logic [3:0]  id_alu_control;

    assign id_imm_sext    = {{16{bus.id_imm16[15]}}, bus.id_imm16};
    assign id_write_reg   = bus.id_RegDst ? bus.id_rd : bus.id_rt;
    assign id_alu_control = alu_decode(bus.id_ALUOp, bus.id_funct);

    // -----------------------------------------------------------------------
    // Register update
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            // Reset and flush both leave a clean bubble; data is cleared too
            // so nothing from the discarded instruction can leak forward.
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            write_reg_q   <= '0;
            alu_control_q <= '0;
            valid_q       <= 1'b0;
            alusrc_q      <= 1'b0;
            regwrite_q    <= 1'b0;
            memread_q     <= 1'b0;
            memwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
        end else if (!bus.stall) begin
            rs_data_q     <= bus.id_rs_data;
            rt_data_q     <= bus.id_rt_data;
            imm_q         <= id_imm_sext;
            rs_q          <= bus.id_rs;
            rt_q          <= bus.id_rt;
            write_reg_q   <= id_write_reg;
            alu_control_q <= id_alu_control;
            alusrc_q      <= bus.id_ALUSrc;
            valid_q       <= bus.id_valid;
            // An invalid slot must not write registers or touch memory.
            regwrite_q    <= bus.id_valid & bus.id_RegWrite;
            memread_q     <= bus.id_valid & bus.id_MemRead;
            memwrite_q    <= bus.id_valid & bus.id_MemWrite;
            memtoreg_q    <= bus.id_valid & bus.id_MemtoReg;
        end
    end

    // -----------------------------------------------------------------------
    // Operand forwarding
    // -----------------------------------------------------------------------
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
`ifdef ID_EX_FORWARD_EN
        // EX/MEM holds the younger result, so it is checked first. Register 0
        // is hard-wired to zero and is never a forwarding target.
        if (bus.exmem_RegWrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rs_q)) begin
            fwd_rs = bus.exmem_result;
        end else if (bus.memwb_RegWrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rs_q)) begin
            fwd_rs = bus.memwb_data;
        end

        if (bus.exmem_RegWrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rt_q)) begin
            fwd_rt = bus.exmem_result;
        end else if (bus.memwb_RegWrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rt_q)) begin
            fwd_rt = bus.memwb_data;
        end
`endif
    end

`ifndef ID_EX_FORWARD_EN
    // Writeback sources are deliberately unused when forwarding is disabled.
    logic unused_fwd_sources;
    assign unused_fwd_sources = ^{bus.exmem_RegWrite, bus.exmem_rd, bus.exmem_result,
                                  bus.memwb_RegWrite, bus.memwb_rd, bus.memwb_data};
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.data1        = fwd_rs;
    assign bus.data2        = alusrc_q ? imm_q : fwd_rt;
    assign bus.ex_rt_data   = fwd_rt;   // store data is always the rt value
    assign bus.ALU_control  = alu_control_q;
    assign bus.ex_valid     = valid_q;
    assign bus.ex_write_reg = write_reg_q;
    assign bus.ex_RegWrite  = regwrite_q;
    assign bus.ex_MemRead   = memread_q;
    assign bus.ex_MemWrite  = memwrite_q;
    assign bus.ex_MemtoReg  = memtoreg_q;

    // A load in EX whose destination is read by the instruction now in ID
    // cannot be forwarded in time; ID/IF must hold for one cycle. The request
    // does not depend on stall so it stays asserted while the pipe is held.
    assign bus.load_use_stall = valid_q & memread_q & (rt_q != 5'd0) &
                                ((rt_q == bus.id_rs) | (rt_q == bus.id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Scoreboard bench for id_ex_stage. A driver applies one stimulus per cycle
// (directed cases first, then random), advances a behavioural model of the
// instruction sitting in EX and queues the outputs that instruction must
// produce. A monitor pops and compares on every falling edge.
// Compile with +define+ID_EX_FORWARD_EN to exercise the forwarding build.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One cycle of stimulus: stage controls, ID instruction, writeback sources.
    typedef struct {
        bit        rst;
        bit        id_valid;
        bit        stall;
        bit        flush;
        bit [31:0] rs_data;
        bit [31:0] rt_data;
        bit [15:0] imm;
        bit [4:0]  rs;
        bit [4:0]  rt;
        bit [4:0]  rd;
        bit [5:0]  funct;
        bit [1:0]  aluop;
        bit        alusrc;
        bit        regdst;
        bit        regwrite;
        bit        memread;
        bit        memwrite;
        bit        memtoreg;
        bit        exm_we;
        bit [4:0]  exm_rd;
        bit [31:0] exm_res;
        bit        mwb_we;
        bit [4:0]  mwb_rd;
        bit [31:0] mwb_data;
    } stim_t;

    // The instruction held in EX, as an abstract record.
    typedef struct {
        bit        valid;
        bit [4:0]  rs;
        bit [4:0]  rt;
        bit [4:0]  dest;
        bit [31:0] rs_val;
        bit [31:0] rt_val;
        int        imm;       // signed immediate value
        bit        use_imm;
        bit [3:0]  op;
        bit        regwrite;
        bit        memread;
        bit        memwrite;
        bit        memtoreg;
    } slot_t;

    typedef struct {
        bit [31:0] data1;
        bit [31:0] data2;
        bit [31:0] rt_data;
        bit [3:0]  alu;
        bit        valid;
        bit [4:0]  wr;
        bit        regwrite;
        bit        memread;
        bit        memwrite;
        bit        memtoreg;
        bit        lus;
    } exp_t;

    exp_t  exp_q[$];
    slot_t slot;
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU operation from the decode table.
    function automatic bit [3:0] alu_of(input bit [1:0] aluop, input bit [5:0] funct);
        if (aluop == 2'b00) return 4'd2;
        if (aluop == 2'b01) return 4'd6;
        if (aluop == 2'b11) return 4'd15;
        case (funct)
            6'h20:   return 4'd2;
            6'h22:   return 4'd6;
            6'h24:   return 4'd0;
            6'h25:   return 4'd1;
            6'h2A:   return 4'd7;
            6'h27:   return 4'd12;
            default: return 4'd15;
        endcase
    endfunction

    // Value of register r as seen by EX, given the writeback sources.
    function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] held, input stim_t s);
`ifdef ID_EX_FORWARD_EN
        if (r != 0 && s.exm_we && s.exm_rd == r) return s.exm_res;
        if (r != 0 && s.mwb_we && s.mwb_rd == r) return s.mwb_data;
`endif
        return held;
    endfunction

    function automatic slot_t next_slot(input slot_t cur, input stim_t s);
        slot_t n;
        n = '{default: 0};
        if (s.rst || s.flush) return n;
        if (s.stall) return cur;
        n.valid    = s.id_valid;
        n.rs       = s.rs;
        n.rt       = s.rt;
        n.dest     = s.regdst ? s.rd : s.rt;
        n.rs_val   = s.rs_data;
        n.rt_val   = s.rt_data;
        n.imm      = int'($signed(s.imm));
        n.use_imm  = s.alusrc;
        n.op       = alu_of(s.aluop, s.funct);
        n.regwrite = s.id_valid && s.regwrite;
        n.memread  = s.id_valid && s.memread;
        n.memwrite = s.id_valid && s.memwrite;
        n.memtoreg = s.id_valid && s.memtoreg;
        return n;
    endfunction

    function automatic exp_t outputs_of(input slot_t sl, input stim_t s);
        exp_t e;
        bit [31:0] rt_v;
        rt_v       = operand(sl.rt, sl.rt_val, s);
        e.data1    = operand(sl.rs, sl.rs_val, s);
        e.data2    = sl.use_imm ? 32'(sl.imm) : rt_v;
        e.rt_data  = rt_v;
        e.alu      = sl.op;
        e.valid    = sl.valid;
        e.wr       = sl.dest;
        e.regwrite = sl.regwrite;
        e.memread  = sl.memread;
        e.memwrite = sl.memwrite;
        e.memtoreg = sl.memtoreg;
        e.lus      = sl.valid && sl.memread && sl.rt != 0 && (sl.rt == s.rs || sl.rt == s.rt);
        return e;
    endfunction

    task automatic drive(input stim_t s);
        rst                = s.rst;
        bus.id_valid       = s.id_valid;
        bus.stall          = s.stall;
        bus.flush          = s.flush;
        bus.id_rs_data     = s.rs_data;
        bus.id_rt_data     = s.rt_data;
        bus.id_imm16       = s.imm;
        bus.id_rs          = s.rs;
        bus.id_rt          = s.rt;
        bus.id_rd          = s.rd;
        bus.id_funct       = s.funct;
        bus.id_ALUOp       = s.aluop;
        bus.id_ALUSrc      = s.alusrc;
        bus.id_RegDst      = s.regdst;
        bus.id_RegWrite    = s.regwrite;
        bus.id_MemRead     = s.memread;
        bus.id_MemWrite    = s.memwrite;
        bus.id_MemtoReg    = s.memtoreg;
        bus.exmem_RegWrite = s.exm_we;
        bus.exmem_rd       = s.exm_rd;
        bus.exmem_result   = s.exm_res;
        bus.memwb_RegWrite = s.mwb_we;
        bus.memwb_rd       = s.mwb_rd;
        bus.memwb_data     = s.mwb_data;
    endtask

    // Drive after the falling edge, let one rising edge capture, then queue
    // the outputs expected until the next stimulus is applied.
    task automatic apply(input stim_t s);
        @(negedge clk);
        #1;
        drive(s);
        @(posedge clk);
        #1;
        slot = next_slot(slot, s);
        exp_q.push_back(outputs_of(slot, s));
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst      = ($urandom_range(0, 39) == 0);
        s.id_valid = ($urandom_range(0, 3) != 0);
        s.stall    = ($urandom_range(0, 4) == 0);
        s.flush    = ($urandom_range(0, 7) == 0);
        s.rs_data  = $urandom;
        s.rt_data  = $urandom;
        s.imm      = 16'($urandom);
        s.rs       = 5'($urandom_range(0, 7));
        s.rt       = 5'($urandom_range(0, 7));
        s.rd       = 5'($urandom_range(0, 31));
        s.funct    = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'(32 + $urandom_range(0, 10));
        s.aluop    = 2'($urandom);
        s.alusrc   = 1'($urandom);
        s.regdst   = 1'($urandom);
        s.regwrite = 1'($urandom);
        s.memread  = 1'($urandom);
        s.memwrite = 1'($urandom);
        s.memtoreg = 1'($urandom);
        s.exm_we   = 1'($urandom);
        s.exm_rd   = 5'($urandom_range(0, 7));
        s.exm_res  = $urandom;
        s.mwb_we   = 1'($urandom);
        s.mwb_rd   = 5'($urandom_range(0, 7));
        s.mwb_data = $urandom;
        return s;
    endfunction

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data1",          bus.data1,                 e.data1);
                check("data2",          bus.data2,                 e.data2);
                check("ex_rt_data",     bus.ex_rt_data,            e.rt_data);
                check("ALU_control",    32'(bus.ALU_control),      32'(e.alu));
                check("ex_valid",       32'(bus.ex_valid),         32'(e.valid));
                check("ex_write_reg",   32'(bus.ex_write_reg),     32'(e.wr));
                check("ex_RegWrite",    32'(bus.ex_RegWrite),      32'(e.regwrite));
                check("ex_MemRead",     32'(bus.ex_MemRead),       32'(e.memread));
                check("ex_MemWrite",    32'(bus.ex_MemWrite),      32'(e.memwrite));
                check("ex_MemtoReg",    32'(bus.ex_MemtoReg),      32'(e.memtoreg));
                check("load_use_stall", 32'(bus.load_use_stall),   32'(e.lus));
            end
        end
    end

    // Driver with directed cases and a few constant spot checks.
    initial begin
        stim_t s;
        slot = '{default: 0};
        s    = '{default: 0};
        s.rst = 1'b1;
        drive(s);

        // Reset for one edge: everything reads zero.
        apply(s);
        check("rst_ex_valid",    32'(bus.ex_valid),       32'd0);
        check("rst_alu",         32'(bus.ALU_control),    32'd0);
        check("rst_write_reg",   32'(bus.ex_write_reg),   32'd0);
        check("rst_data1",       bus.data1,               32'd0);
        check("rst_data2",       bus.data2,               32'd0);
        check("rst_lus",         32'(bus.load_use_stall), 32'd0);

        // slt r7, r3, r4 with r3=5, r4=9.
        s = '{default: 0};
        s.id_valid = 1; s.aluop = 2'b10; s.funct = 6'h2A;
        s.rs = 5'd3; s.rs_data = 32'd5; s.rt = 5'd4; s.rt_data = 32'd9;
        s.regdst = 1; s.rd = 5'd7; s.regwrite = 1;
        apply(s);
        check("slt_alu",   32'(bus.ALU_control), 32'd7);
        check("slt_data1", bus.data1,            32'd5);
        check("slt_data2", bus.data2,            32'd9);
        check("slt_wr",    32'(bus.ex_write_reg), 32'd7);

        // Negative immediate: sign extension and add.
        s = '{default: 0};
        s.id_valid = 1; s.aluop = 2'b00; s.alusrc = 1; s.imm = 16'hFFFC;
        s.rs = 5'd1; s.rs_data = 32'd100; s.rt = 5'd2; s.regwrite = 1;
        apply(s);
        check("imm_data2", bus.data2,            32'hFFFF_FFFC);
        check("imm_alu",   32'(bus.ALU_control), 32'd2);

        // Forwarding priority on rs=3: both sources match, then EX/MEM rd=0.
        s = '{default: 0};
        s.id_valid = 1; s.rs = 5'd3; s.rs_data = 32'h99;
        s.exm_we = 1; s.exm_rd = 5'd3; s.exm_res = 32'h11;
        s.mwb_we = 1; s.mwb_rd = 5'd3; s.mwb_data = 32'h22;
        apply(s);
`ifdef ID_EX_FORWARD_EN
        check("fwd_exmem", bus.data1, 32'h11);
`else
        check("fwd_off_a", bus.data1, 32'h99);
`endif
        s.stall = 1; s.exm_rd = 5'd0; s.rs_data = 32'h55;
        apply(s);
`ifdef ID_EX_FORWARD_EN
        check("fwd_memwb", bus.data1, 32'h22);
`else
        check("fwd_off_b", bus.data1, 32'h99);
`endif

        // Load into r8 followed by a reader of r8, then flush under stall.
        s = '{default: 0};
        s.id_valid = 1; s.memread = 1; s.memtoreg = 1; s.regwrite = 1;
        s.alusrc = 1; s.rt = 5'd8; s.rs = 5'd8;
        apply(s);
        check("lus_set", 32'(bus.load_use_stall), 32'd1);
        s = '{default: 0};
        s.id_valid = 1; s.rs = 5'd8; s.regwrite = 1; s.flush = 1; s.stall = 1;
        apply(s);
        check("flush_valid",   32'(bus.ex_valid),       32'd0);
        check("flush_memread", 32'(bus.ex_MemRead),     32'd0);
        check("flush_regwr",   32'(bus.ex_RegWrite),    32'd0);
        check("flush_lus",     32'(bus.load_use_stall), 32'd0);

        // Random traffic, including mid-stream resets.
        for (int i = 0; i < 800; i++) begin
            apply(rand_stim());
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
